shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//  Multicycle sequencer for the shift unit (RegDesloc) and its input/amount muxes.
//  Accepts a shift op from the main control FSM and drives the shift-input select, shift-amount select and shifter command.
//  Sequence per op: LOAD, SHIFT, write-back strobe. Start/busy/done handshake frees the main FSM from per-cycle shifter control.
// PARAMETERS
//  SKIP_ZERO  1  1: when n_is_zero is seen in LOAD, go LOAD->DONE, no SHIFT cycle; 0: always run SHIFT.
// PORTS
//  clk          in   1  single clock; all state changes on rising edge
//  reset        in   1  asynchronous, active-high; forces IDLE and all outputs to reset values
//  start        in   1  request; sampled only in IDLE
//  op           in   3  000 SLL, 001 SRL, 010 SRA, 011 SLLV, 100 SRLV, 101 SRAV, 110 LUI, 111 illegal
//  n_is_zero    in   1  datapath flag: selected shift amount == 0; valid during LOAD
//  in_sel       out  2  shift-input mux select: 00 B(rt), 01 A(rs), 10 immediate
//  n_sel        out  2  shift-amount mux select: 00 shamt field, 01 A[4:0], 10 const 16
//  sh_cmd       out  3  shifter cmd: 000 nop, 001 load, 010 left n, 011 right logical n, 100 right arith n
//  busy         out  1  high from the cycle after an accepted start through DONE inclusive
//  done         out  1  one-cycle pulse in DONE
//  result_we    out  1  write strobe for the destination register; high in DONE only if op legal
//  err          out  1  high in DONE only for op 111
// BEHAVIOUR
//  Reset: state IDLE; in_sel=00, n_sel=00, sh_cmd=000, busy=0, done=0, result_we=0, err=0.
//  All outputs are registered or decoded from the state and latched op only; no combinational path from start/op to outputs.
//  IDLE: start=1 latches op. Legal op -> LOAD. op=111 -> DONE with err=1. start=0 -> stay.
//  LOAD: sh_cmd=001; in_sel/n_sel from latched op. If SKIP_ZERO and n_is_zero -> DONE; else -> SHIFT.
//  SHIFT: sh_cmd = 010 (SLL/SLLV/LUI), 011 (SRL/SRLV), 100 (SRA/SRAV); next state DONE.
//  DONE: sh_cmd=000; done=1; result_we=~err; next state IDLE. New start is accepted in the following IDLE cycle.
//  Latency: start at edge T -> done high in cycle T+3 (T+2 on zero-skip, T+1 on illegal). Back-to-back rate is one op every 4 cycles.
//  Select map: SLL/SRL/SRA in=00 n=00; SLLV/SRLV/SRAV in=00 n=01; LUI in=10 n=10.
//  in_sel/n_sel hold their value from LOAD through DONE. They return to 00 in IDLE.
//  start/op changes while busy are ignored; the latched op is not overwritten.
//  Reset asserted mid-sequence: immediate IDLE. No done or result_we is issued for the aborted op.
//  Illegal op path never issues sh_cmd!=000.
// STRUCTURE
//  Shared header shift_ctrl_defs.vh holds the following, all consumed by the main control FSM too:
//   - op codes, sh_cmd codes and in_sel/n_sel codes
//   - state encodings: IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3
//  One sub-module, shift_op_decode (combinational): latched op -> {in_sel, n_sel, shift_cmd, illegal}.
//  Top level holds the state register, the op latch and the output registers.
// TESTING
//  1. Reset held, then released -> all outputs 0, state IDLE. Reset pulse during SHIFT of SRA -> next cycle sh_cmd=000, busy=0, no done.
//  2. start, op=000 (SLL), n_is_zero=0 -> the sequence below:
//     - T+1: sh_cmd=001, in_sel=00, n_sel=00
//     - T+2: sh_cmd=010
//     - T+3: done=1, result_we=1
//  3. op=101 (SRAV) -> SHIFT cycle sh_cmd=100, n_sel=01. op=110 (LUI) -> in_sel=10, n_sel=10, sh_cmd=010.
//  4. SKIP_ZERO=1, op=001, n_is_zero=1 in LOAD -> done at T+2, no 011 cmd ever. With SKIP_ZERO=0 -> done at T+3.
//  5. op=111 -> done=1, err=1, result_we=0 at T+1; sh_cmd stays 000 throughout.
//  6. start held high continuously with op=100 -> done pulses every 4 cycles. op toggled while busy -> latched op unchanged.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the shift-unit sequencer: op codes, shifter
// command codes, input/amount mux select codes and the FSM state encoding.
// The main control FSM uses the same codes, so keep them in one place.
package shift_seq_ctrl_pkg;

  // Shift op codes presented by the main control FSM
  localparam logic [2:0] OP_SLL     = 3'b000;
  localparam logic [2:0] OP_SRL     = 3'b001;
  localparam logic [2:0] OP_SRA     = 3'b010;
  localparam logic [2:0] OP_SLLV    = 3'b011;
  localparam logic [2:0] OP_SRLV    = 3'b100;
  localparam logic [2:0] OP_SRAV    = 3'b101;
  localparam logic [2:0] OP_LUI     = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  // Shifter (RegDesloc) commands
  localparam logic [2:0] CMD_NOP     = 3'b000;
  localparam logic [2:0] CMD_LOAD    = 3'b001;
  localparam logic [2:0] CMD_LEFT    = 3'b010;
  localparam logic [2:0] CMD_RIGHT_L = 3'b011;
  localparam logic [2:0] CMD_RIGHT_A = 3'b100;

  // Shift-input mux selects
  localparam logic [1:0] IN_B   = 2'b00;
  localparam logic [1:0] IN_A   = 2'b01;
  localparam logic [1:0] IN_IMM = 2'b10;

  // Shift-amount mux selects
  localparam logic [1:0] N_SHAMT = 2'b00;
  localparam logic [1:0] N_A     = 2'b01;
  localparam logic [1:0] N_16    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_seq_ctrl_op_decode.sv
// shift_op_decode: combinational decode of a shift op into the mux selects
// and the shifter command used during the SHIFT cycle.
// Ports:
//   op        in  3  shift op code
//   in_sel    out 2  shift-input mux select
//   n_sel     out 2  shift-amount mux select
//   shift_cmd out 3  shifter command for the SHIFT cycle
//   illegal   out 1  op code 111
module shift_op_decode
  import shift_seq_ctrl_pkg::*;
(
  input  logic [2:0] op,
  output logic [1:0] in_sel,
  output logic [1:0] n_sel,
  output logic [2:0] shift_cmd,
  output logic       illegal
);

  always_comb begin
    in_sel    = IN_B;
    n_sel     = N_SHAMT;
    shift_cmd = CMD_NOP;
    illegal   = 1'b0;
    case (op)
      OP_SLL:  shift_cmd = CMD_LEFT;
      OP_SRL:  shift_cmd = CMD_RIGHT_L;
      OP_SRA:  shift_cmd = CMD_RIGHT_A;
      OP_SLLV: begin n_sel = N_A; shift_cmd = CMD_LEFT;    end
      OP_SRLV: begin n_sel = N_A; shift_cmd = CMD_RIGHT_L; end
      OP_SRAV: begin n_sel = N_A; shift_cmd = CMD_RIGHT_A; end
      OP_LUI: begin
        in_sel    = IN_IMM;
        n_sel     = N_16;
        shift_cmd = CMD_LEFT;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multicycle sequencer for the shift unit. Takes one shift
// op from the main control FSM and walks LOAD -> SHIFT -> DONE, driving the
// shifter command and its input/amount mux selects, then strobes the
// destination write in DONE.
// Ports:
//   clk        in  1  clock
//   reset      in  1  asynchronous active-high reset
//   start      in  1  op request, sampled only in IDLE
//   op         in  3  shift op code
//   n_is_zero  in  1  selected shift amount is zero (valid in LOAD)
//   in_sel     out 2  shift-input mux select
//   n_sel      out 2  shift-amount mux select
//   sh_cmd     out 3  shifter command
//   busy       out 1  sequence in progress (LOAD..DONE)
//   done       out 1  one-cycle completion pulse
//   result_we  out 1  destination write strobe (legal ops only)
//   err        out 1  illegal op reported in DONE
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       n_is_zero,
  output logic [1:0] in_sel,
  output logic [1:0] n_sel,
  output logic [2:0] sh_cmd,
  output logic       busy,
  output logic       done,
  output logic       result_we,
  output logic       err
);

  state_t     state_reg;
  logic [2:0] op_reg;
  logic [1:0] in_sel_reg;
  logic [1:0] n_sel_reg;
  logic [2:0] sh_cmd_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       result_we_reg;
  logic       err_reg;

  // In IDLE the decoder looks at the incoming op so the LOAD-cycle selects
  // can be registered on the accepting edge; afterwards it only sees the
  // latched op, so op changes while busy have no effect.
  logic [2:0] dec_op;
  logic [1:0] dec_in_sel;
  logic [1:0] dec_n_sel;
  logic [2:0] dec_shift_cmd;
  logic       dec_illegal;

  assign dec_op = (state_reg == ST_IDLE) ? op : op_reg;

  shift_op_decode u_decode (
    .op        (dec_op),
    .in_sel    (dec_in_sel),
    .n_sel     (dec_n_sel),
    .shift_cmd (dec_shift_cmd),
    .illegal   (dec_illegal)
  );

  // Outputs are registered alongside the state: each edge loads the output
  // values belonging to the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_SLL;
      in_sel_reg    <= IN_B;
      n_sel_reg     <= N_SHAMT;
      sh_cmd_reg    <= CMD_NOP;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      result_we_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            op_reg   <= op;
            busy_reg <= 1'b1;
            if (dec_illegal) begin
              // Illegal op goes straight to DONE; the shifter is never touched.
              state_reg     <= ST_DONE;
              sh_cmd_reg    <= CMD_NOP;
              done_reg      <= 1'b1;
              err_reg       <= 1'b1;
              result_we_reg <= 1'b0;
            end else begin
              state_reg  <= ST_LOAD;
              sh_cmd_reg <= CMD_LOAD;
              in_sel_reg <= dec_in_sel;
              n_sel_reg  <= dec_n_sel;
            end
          end
        end
        ST_LOAD: begin
          if (SKIP_ZERO && n_is_zero) begin
            // Zero shift amount: loaded value is already the result.
            state_reg     <= ST_DONE;
            sh_cmd_reg    <= CMD_NOP;
            done_reg      <= 1'b1;
            result_we_reg <= 1'b1;
          end else begin
            state_reg  <= ST_SHIFT;
            sh_cmd_reg <= dec_shift_cmd;
          end
        end
        ST_SHIFT: begin
          state_reg     <= ST_DONE;
          sh_cmd_reg    <= CMD_NOP;
          done_reg      <= 1'b1;
          result_we_reg <= 1'b1;
        end
        default: begin
          // DONE: back to IDLE with every output at rest.
          state_reg     <= ST_IDLE;
          in_sel_reg    <= IN_B;
          n_sel_reg     <= N_SHAMT;
          sh_cmd_reg    <= CMD_NOP;
          busy_reg      <= 1'b0;
          done_reg      <= 1'b0;
          result_we_reg <= 1'b0;
          err_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign in_sel    = in_sel_reg;
  assign n_sel     = n_sel_reg;
  assign sh_cmd    = sh_cmd_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign result_we = result_we_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl. Two instances run in lockstep,
// one with zero-skip enabled and one without. Expected per-cycle outputs
// come from a rule-based model of the op sequence.
module tb_shift_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic       n_is_zero;

  logic [1:0] in_sel0, n_sel0, in_sel1, n_sel1;
  logic [2:0] sh_cmd0, sh_cmd1;
  logic       busy0, done0, we0, err0;
  logic       busy1, done1, we1, err1;

  int total_cnt = 0;
  int pass_cnt  = 0;

  shift_seq_ctrl #(.SKIP_ZERO(1'b1)) dut_skip (
    .clk(clk), .reset(reset), .start(start), .op(op), .n_is_zero(n_is_zero),
    .in_sel(in_sel0), .n_sel(n_sel0), .sh_cmd(sh_cmd0), .busy(busy0),
    .done(done0), .result_we(we0), .err(err0)
  );

  shift_seq_ctrl #(.SKIP_ZERO(1'b0)) dut_noskip (
    .clk(clk), .reset(reset), .start(start), .op(op), .n_is_zero(n_is_zero),
    .in_sel(in_sel1), .n_sel(n_sel1), .sh_cmd(sh_cmd1), .busy(busy1),
    .done(done1), .result_we(we1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row layout: {in_sel, n_sel, sh_cmd, busy, done, result_we, err}
  function automatic logic [10:0] row(input logic [1:0] i, input logic [1:0] n,
                                      input logic [2:0] c, input logic b,
                                      input logic d, input logic w, input logic e);
    return {i, n, c, b, d, w, e};
  endfunction

  // Expected outputs k cycles after the accepting edge (k >= 1).
  function automatic logic [10:0] model(input logic [2:0] o, input logic nz,
                                        input bit skip, input int k);
    logic [1:0] i, n;
    logic [2:0] c;
    bit skipped;
    case (o)
      3'd0: begin i = 2'd0; n = 2'd0; c = 3'd2; end
      3'd1: begin i = 2'd0; n = 2'd0; c = 3'd3; end
      3'd2: begin i = 2'd0; n = 2'd0; c = 3'd4; end
      3'd3: begin i = 2'd0; n = 2'd1; c = 3'd2; end
      3'd4: begin i = 2'd0; n = 2'd1; c = 3'd3; end
      3'd5: begin i = 2'd0; n = 2'd1; c = 3'd4; end
      3'd6: begin i = 2'd2; n = 2'd2; c = 3'd2; end
      default: begin i = 2'd0; n = 2'd0; c = 3'd0; end
    endcase
    if (o == 3'd7)
      return (k == 1) ? row(2'd0, 2'd0, 3'd0, 1, 1, 0, 1) : 11'd0;
    skipped = skip && nz;
    if (k == 1) return row(i, n, 3'd1, 1, 0, 0, 0);
    if (k == 2) return skipped ? row(i, n, 3'd0, 1, 1, 1, 0) : row(i, n, c, 1, 0, 0, 0);
    if (k == 3) return skipped ? 11'd0 : row(i, n, 3'd0, 1, 1, 1, 0);
    return 11'd0;
  endfunction

  function automatic logic [10:0] obs0();
    return {in_sel0, n_sel0, sh_cmd0, busy0, done0, we0, err0};
  endfunction
  function automatic logic [10:0] obs1();
    return {in_sel1, n_sel1, sh_cmd1, busy1, done1, we1, err1};
  endfunction

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      $display("FAIL %s observed=%h expected=%h", tag, got, exp);
      $error("%s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [10:0] e0, input logic [10:0] e1);
    check({tag, "_skip"}, obs0(), e0);
    check({tag, "_noskip"}, obs1(), e1);
  endtask

  // One op: start for a single cycle, then scramble op while busy.
  task automatic run_op(input logic [2:0] o, input logic nz);
    @(negedge clk);
    start = 1'b1; op = o; n_is_zero = nz;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      check_both($sformatf("op%0d_nz%0d_c%0d", o, nz, k),
                 model(o, nz, 1'b1, k), model(o, nz, 1'b0, k));
      op = 3'($urandom_range(0, 7));
    end
    $display("txn op=%0d nz=%0d done", o, nz);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; n_is_zero = 1'b0;
    repeat (2) @(negedge clk);
    check_both("reset_held", 11'd0, 11'd0);
    reset = 1'b0;
    @(negedge clk);
    check_both("after_reset", 11'd0, 11'd0);

    run_op(3'd0, 1'b0);  // SLL
    run_op(3'd5, 1'b0);  // SRAV
    run_op(3'd6, 1'b0);  // LUI
    run_op(3'd1, 1'b1);  // SRL zero amount
    run_op(3'd7, 1'b0);  // illegal
    run_op(3'd7, 1'b1);
    run_op(3'd3, 1'b1);

    // Reset during the SHIFT cycle of SRA aborts the op.
    @(negedge clk);
    start = 1'b1; op = 3'd2; n_is_zero = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_both("abort_load", model(3'd2, 0, 1, 1), model(3'd2, 0, 0, 1));
    @(negedge clk);
    check_both("abort_shift", model(3'd2, 0, 1, 2), model(3'd2, 0, 0, 2));
    reset = 1'b1;
    #1;
    check_both("abort_async", 11'd0, 11'd0);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_both($sformatf("abort_idle_c%0d", k), 11'd0, 11'd0);
    end
    $display("txn abort-by-reset done");

    // start held high with SRLV: one op every 4 cycles, op noise ignored.
    @(negedge clk);
    start = 1'b1; op = 3'd4; n_is_zero = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check_both($sformatf("b2b_c%0d", k),
                 model(3'd4, 0, 1, ((k - 1) % 4) + 1), model(3'd4, 0, 0, ((k - 1) % 4) + 1));
      if ((k - 1) % 4 == 3) op = 3'd4;
      else                  op = 3'($urandom_range(0, 7));
    end
    start = 1'b0;
    $display("txn back-to-back done");

    for (int t = 0; t < 24; t++)
      run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
